dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Two-port arbiter that shares the single-ported data memory between the pipeline MEM stage (CPU port) and a DMA/loader port. It sits between the MEM stage and `DM`, and drives DM's `in_addr`, `in_data` and `w_code`. The CPU normally has priority. A bounded-wait counter guarantees DMA forward progress: it stalls the pipeline for one cycle whenever the DMA has waited `MAX_WAIT` cycles. DMA transactions use a req/ack handshake with a registered ack and registered read data.

## Interface
- `ADDR_SIZE`, 32, word address width; passed unchanged to DM.
- `DATA_SIZE`, 32, data width.
- `CODE_SIZE`, 6, width of DM write code.
- `SW_CODE`, 6'd3, code that makes DM store.
- `MAX_WAIT`, 4, number of consecutive losing cycles after which DMA wins; legal range 1..255.

- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `cpu_req`  in  1  MEM stage wants memory this cycle.
- `cpu_we`  in  1  1 = store, 0 = load.
- `cpu_addr`  in  ADDR_SIZE  word address.
- `cpu_wdata`  in  DATA_SIZE  store data.
- `cpu_rdata`  out  DATA_SIZE  load data; combinational from `dm_rdata`.
- `cpu_stall`  out  1  combinational; freezes the pipeline.
- `dma_req`  in  1  held high until `dma_ack` is sampled.
- `dma_we`  in  1  1 = write, 0 = read.
- `dma_addr`  in  ADDR_SIZE  word address.
- `dma_wdata`  in  DATA_SIZE  write data.
- `dma_ack`  out  1  registered one-cycle pulse.
- `dma_rdata`  out  DATA_SIZE  registered read data; valid while `dma_ack` = 1.
- `dm_addr`  out  ADDR_SIZE  to DM `in_addr`.
- `dm_data`  out  DATA_SIZE  to DM `in_data`.
- `dm_wcode`  out  CODE_SIZE  to DM `w_code`.
- `dm_rdata`  in  DATA_SIZE  from DM `o_data` (combinational read).

## Operation
- State machine has two states:
  - ARB: normal arbitration; DMA is eligible.
  - DACK: ack cycle; DMA is ineligible and the CPU may use the port.
- Wait counter `wait_cnt` is 8 bits and saturates at `MAX_WAIT`.
- DMA eligibility: `dma_elig` = `dma_req` && state == ARB.
- Grant logic, combinational:
  - `gnt_dma` = `dma_elig` && (!`cpu_req` || `wait_cnt` == `MAX_WAIT`).
  - `gnt_cpu` = `cpu_req` && !`gnt_dma`.
  - Both grants are forced to 0 while `rst` = 1.
- Port mux:
  - Granted owner drives `dm_addr` and `dm_data`.
  - `dm_wcode` = `SW_CODE` if the owner's `we` = 1, else 0.
  - With no grant, all three are 0 (no store).
- `cpu_stall` = `cpu_req` && !`gnt_cpu`.
- `cpu_rdata` = `dm_rdata` at all times; meaningful only when `gnt_cpu` && !`cpu_we`.
- Transitions:
  - ARB -> DACK on `gnt_dma`.
  - DACK -> ARB always, after one cycle.
- `wait_cnt` update:
  - Cleared on `gnt_dma`.
  - Incremented (saturating) when `dma_elig` && !`gnt_dma`.
  - Unchanged otherwise.
- On a `gnt_dma` cycle, registered at posedge: `dma_ack` <= 1 and `dma_rdata` <= `dm_rdata` (loaded for writes too; value is don't-care).
- `dma_ack` is cleared on every other cycle.

## Timing
- Reset values: state = ARB, `wait_cnt` = 0, `dma_ack` = 0, `dma_rdata` = 0.
- Combinational outputs during reset: `dm_wcode` = 0, `dm_addr` = 0, `dm_data` = 0, `cpu_stall` = `cpu_req`.
- CPU latency is zero: load data in the grant cycle; store commits at DM's negedge inside the grant cycle.
- DMA latency: grant in cycle N; store commits at the negedge of N; `dma_ack` and `dma_rdata` are valid in cycle N+1.
- The requester samples ack at the end of N+1 and must drop `dma_req` or present a new request in N+2. In N+1 the request is ignored (state DACK).
- Minimum DMA issue interval is 2 cycles.
- Maximum CPU stall per DMA transfer is 1 cycle.
- Maximum DMA wait under continuous `cpu_req` is `MAX_WAIT` cycles before grant.
- Simultaneous requests with `wait_cnt` < `MAX_WAIT`: CPU wins and the counter increments.
- `dma_req` dropped before grant: `wait_cnt` holds its value (no clear) until the next grant.
- Reset asserted during a DMA grant cycle: the store is suppressed and state returns to ARB, so the DMA never sees an ack and must re-request.

## Test plan
- CPU-only traffic:
  - Store 0xDEADBEEF to addr 5, then load addr 5 on the next cycle.
  - Expect `dm_wcode` = 3 on the store cycle, `cpu_rdata` = 0xDEADBEEF, `cpu_stall` = 0 throughout.
- DMA-only traffic:
  - Write 0x1234 to addr 9, then read addr 9.
  - Expect each ack exactly 1 cycle after its grant and `dma_rdata` = 0x1234 with the second ack.
  - Expect `dma_req` held through the ack cycle to produce no second grant.
- Starvation bound:
  - Hold `cpu_req` = 1 continuously with `dma_req` = 1 and `MAX_WAIT` = 4.
  - Expect DMA granted on the 5th cycle with `cpu_stall` = 1 for exactly that cycle, and `wait_cnt` back to 0 afterwards.
- Back-to-back DMA with idle CPU:
  - Expect grants on every other cycle (ARB/DACK alternation).
  - Expect a CPU request in a DACK cycle to be granted with no stall.
- Reset mid-transfer:
  - Assert `rst` in the DMA grant cycle of a write of 0xAA to addr 3.
  - Expect `dm_wcode` = 0 (addr 3 unchanged), `dma_ack` = 0 next cycle, state = ARB, `wait_cnt` = 0.
- Idle port:
  - No requests.
  - Expect `dm_addr`, `dm_data` and `dm_wcode` all 0 and `dma_ack` = 0.

Source files
------------

// File: rtl/dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dm_arbiter
// Description : Shares the single-ported data memory between the CPU MEM stage
//               and a DMA port; CPU-priority with a bounded DMA wait.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_arbiter #(
    parameter int unsigned                ADDR_SIZE = 32,
    parameter int unsigned                DATA_SIZE = 32,
    parameter int unsigned                CODE_SIZE = 6,
    parameter logic [CODE_SIZE-1:0]       SW_CODE   = 6'd3,
    parameter int unsigned                MAX_WAIT  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_SIZE-1:0] cpu_addr,
    input  logic [DATA_SIZE-1:0] cpu_wdata,
    output logic [DATA_SIZE-1:0] cpu_rdata,
    output logic                 cpu_stall,
    input  logic                 dma_req,
    input  logic                 dma_we,
    input  logic [ADDR_SIZE-1:0] dma_addr,
    input  logic [DATA_SIZE-1:0] dma_wdata,
    output logic                 dma_ack,
    output logic [DATA_SIZE-1:0] dma_rdata,
    output logic [ADDR_SIZE-1:0] dm_addr,
    output logic [DATA_SIZE-1:0] dm_data,
    output logic [CODE_SIZE-1:0] dm_wcode,
    input  logic [DATA_SIZE-1:0] dm_rdata
);

    localparam logic [7:0] c_max_wait = MAX_WAIT[7:0];

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        DACK = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [7:0]           r_wait_cnt;
    logic                 r_dma_ack;
    logic [DATA_SIZE-1:0] r_dma_rdata;

    logic                 w_dma_elig;
    logic                 w_gnt_dma;
    logic                 w_gnt_cpu;

    assign w_dma_elig = dma_req && (r_state == ARB);
    // Grants are masked during reset so a store in flight never reaches DM.
    assign w_gnt_dma  = !rst && w_dma_elig && (!cpu_req || (r_wait_cnt == c_max_wait));
    assign w_gnt_cpu  = !rst && cpu_req && !w_gnt_dma;

    assign cpu_stall  = cpu_req && !w_gnt_cpu;
    assign cpu_rdata  = dm_rdata;
    assign dma_ack    = r_dma_ack;
    assign dma_rdata  = r_dma_rdata;

    always_comb begin
        dm_addr  = '0;
        dm_data  = '0;
        dm_wcode = '0;
        if (w_gnt_dma) begin
            dm_addr = dma_addr;
            dm_data = dma_wdata;
            if (dma_we) begin
                dm_wcode = SW_CODE;
            end
        end else if (w_gnt_cpu) begin
            dm_addr = cpu_addr;
            dm_data = cpu_wdata;
            if (cpu_we) begin
                dm_wcode = SW_CODE;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB:     if (w_gnt_dma) w_state_nxt = DACK;
            DACK:    w_state_nxt = ARB;
            default: w_state_nxt = ARB;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ARB;
            r_wait_cnt  <= 8'd0;
            r_dma_ack   <= 1'b0;
            r_dma_rdata <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_dma_ack <= w_gnt_dma;
            if (w_gnt_dma) begin
                r_dma_rdata <= dm_rdata;
                r_wait_cnt  <= 8'd0;
            end else if (w_dma_elig && (r_wait_cnt != c_max_wait)) begin
                r_wait_cnt  <= r_wait_cnt + 8'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dm_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_arbiter
// Description : Scoreboard bench for dm_arbiter with a DM model and a
//               cycle-level reference of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_arbiter;

    localparam int unsigned c_max_wait = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0, cpu_wdata = '0;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dma_req = 1'b0, dma_we = 1'b0;
    logic [31:0] dma_addr = '0, dma_wdata = '0;
    logic        dma_ack;
    logic [31:0] dma_rdata;
    logic [31:0] dm_addr, dm_data, dm_rdata;
    logic [5:0]  dm_wcode;

    dm_arbiter #(
        .ADDR_SIZE(32), .DATA_SIZE(32), .CODE_SIZE(6),
        .SW_CODE(6'd3), .MAX_WAIT(c_max_wait)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .dm_addr(dm_addr), .dm_data(dm_data), .dm_wcode(dm_wcode),
        .dm_rdata(dm_rdata)
    );

    always #5 clk = ~clk;

    // Data memory: combinational read, store at negedge.
    logic [31:0] mem [64];
    assign dm_rdata = mem[dm_addr[5:0]];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        forever begin
            @(negedge clk);
            if (dm_wcode == 6'd3) mem[dm_addr[5:0]] = dm_data;
        end
    end

    typedef struct {
        logic        stall;
        logic [31:0] addr;
        logic [31:0] data;
        logic [5:0]  wcode;
        logic        chk_rd;
        logic [31:0] rd;
        logic        ack;
        logic        chk_rst;
    } exp_t;

    typedef struct {
        logic        is_rd;
        logic [31:0] data;
    } dexp_t;

    exp_t  exp_q[$];
    dexp_t dma_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_tests++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
        end
    endtask

    // Reference: who wins each cycle, computed from the arbitration rules.
    logic [31:0] m_mem [64];
    bit          m_ack_pending = 1'b0;
    bit          m_after_gnt   = 1'b0;
    int          m_waited      = 0;
    bit          m_rst_prev    = 1'b0;

    task automatic do_cycle(input logic r, input logic cr, input logic cw,
                            input logic [31:0] ca, input logic [31:0] cd,
                            input logic dr, input logic dw,
                            input logic [31:0] da, input logic [31:0] dd,
                            output logic gd);
        exp_t e;
        bit   elig, gc;
        @(posedge clk); #1;
        rst = r; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
        e = '{stall: 1'b0, addr: '0, data: '0, wcode: '0, chk_rd: 1'b0,
              rd: '0, ack: m_ack_pending, chk_rst: m_rst_prev};
        gd = 1'b0;
        if (r) begin
            e.stall       = cr;
            m_after_gnt   = 1'b0;
            m_waited      = 0;
            m_ack_pending = 1'b0;
        end else begin
            elig = dr && !m_after_gnt;
            gd   = elig && (!cr || m_waited >= int'(c_max_wait));
            gc   = cr && !gd;
            e.stall = cr && !gc;
            if (gd) begin
                e.addr = da; e.data = dd; e.wcode = dw ? 6'd3 : 6'd0;
                dma_q.push_back('{is_rd: !dw, data: m_mem[da[5:0]]});
                if (dw) m_mem[da[5:0]] = dd;
                m_waited = 0;
            end else if (gc) begin
                e.addr = ca; e.data = cd; e.wcode = cw ? 6'd3 : 6'd0;
                e.chk_rd = !cw; e.rd = m_mem[ca[5:0]];
                if (cw) m_mem[ca[5:0]] = cd;
            end
            if (elig && !gd && m_waited < int'(c_max_wait)) m_waited++;
            m_after_gnt   = gd;
            m_ack_pending = gd;
        end
        m_rst_prev = r;
        exp_q.push_back(e);
    endtask

    // Monitor: one expectation per cycle, one DMA expectation per ack.
    initial begin
        exp_t  e;
        dexp_t d;
        forever begin
            @(posedge clk); #4;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("cpu_stall", 32'(cpu_stall), 32'(e.stall));
                chk("dm_addr", dm_addr, e.addr);
                chk("dm_data", dm_data, e.data);
                chk("dm_wcode", 32'(dm_wcode), 32'(e.wcode));
                chk("dma_ack", 32'(dma_ack), 32'(e.ack));
                if (e.chk_rd) chk("cpu_rdata", cpu_rdata, e.rd);
                if (e.chk_rst) chk("dma_rdata_reset", dma_rdata, 32'h0);
            end
            if (dma_ack === 1'b1) begin
                if (dma_q.size() == 0) begin
                    chk("dma_ack_unexpected", 32'(dma_ack), 32'h0);
                end else begin
                    d = dma_q.pop_front();
                    if (d.is_rd) chk("dma_rdata", dma_rdata, d.data);
                end
            end
        end
    end

    initial begin
        logic        g;
        logic        d_pend = 1'b0, d_ackwait = 1'b0, d_we = 1'b0;
        logic [31:0] d_addr = '0, d_data = '0;
        logic        r, cr, cw;
        logic [31:0] ca, cd;
        for (int i = 0; i < 64; i++) m_mem[i] = '0;

        do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, g);
        do_cycle(1, 1, 0, 0, 0, 0, 0, 0, 0, g);
        // idle port
        repeat (2) do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        // CPU store then load
        do_cycle(0, 1, 1, 32'd5, 32'hDEADBEEF, 0, 0, 0, 0, g);
        do_cycle(0, 1, 0, 32'd5, 32'h0, 0, 0, 0, 0, g);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        // DMA write then read, req held through each ack cycle
        repeat (2) do_cycle(0, 0, 0, 0, 0, 1, 1, 32'd9, 32'h1234, g);
        repeat (2) do_cycle(0, 0, 0, 0, 0, 1, 0, 32'd9, 32'h0, g);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        // starvation bound under continuous CPU loads
        for (int i = 0; i < 6; i++)
            do_cycle(0, 1, 0, 32'(i), 0, (i < 5), 0, 32'd9, 0, g);
        repeat (3) do_cycle(0, 1, 0, 32'd5, 0, 0, 0, 0, 0, g);
        // back-to-back DMA, CPU arrives in ack cycles
        for (int i = 0; i < 6; i++)
            do_cycle(0, (i == 1 || i == 3), 0, 32'd5, 0, 1, 1, 32'(10 + i), 32'(i + 100), g);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        // reset in the grant cycle of a DMA write, then read back
        do_cycle(1, 0, 0, 0, 0, 1, 1, 32'd3, 32'hAA, g);
        repeat (2) do_cycle(0, 0, 0, 0, 0, 1, 0, 32'd3, 0, g);
        do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, g);

        // randomized traffic with a protocol-abiding DMA requester
        for (int n = 0; n < 3000; n++) begin
            if (!d_pend && !d_ackwait && $urandom_range(0, 2) == 0) begin
                d_pend = 1'b1;
                d_we   = 1'($urandom_range(0, 1));
                d_addr = 32'($urandom_range(0, 63));
                d_data = $urandom;
            end else if (d_pend && $urandom_range(0, 19) == 0) begin
                d_pend = 1'b0;
            end
            r  = ($urandom_range(0, 99) == 0);
            cr = ($urandom_range(0, 3) != 0);
            cw = 1'($urandom_range(0, 1));
            ca = 32'($urandom_range(0, 63));
            cd = $urandom;
            do_cycle(r, cr, cw, ca, cd, d_pend || d_ackwait, d_we, d_addr, d_data, g);
            d_ackwait = 1'b0;
            if (g) begin
                d_pend    = 1'b0;
                d_ackwait = 1'b1;
            end
        end

        repeat (3) do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, g);
        @(posedge clk); #6;
        chk("exp_q_drained", 32'(exp_q.size()), 32'h0);
        chk("dma_q_drained", 32'(dma_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
